mux8_rr_sched: RTL and testbench

- Round-robin scheduler that shares the team's 8:1 gate-level multiplexer among 8 requesters.
- Arbitrates the request vector and drives the mux select lines (s2,s1,s0) as a 3-bit bus, plus a one-hot grant.
- Enforces a bounded hold time and a break-before-make gap between grants so the mux output never switches directly between two owners.

---
 rtl/mux8_rr_sched.sv | 151 +++++++++++++++
 tb/tb_mux8_rr_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select lines of the shared 8:1 mux, with bounded hold and a
// break-before-make gap. Define MUX8_RR_LOCK_EN to add a lock input that suppresses the hold timeout.
module mux8_rr_sched #(
    parameter int unsigned MAX_HOLD   = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
`ifdef MUX8_RR_LOCK_EN
    input  logic       lock,
`endif
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic [2:0] last_idx
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int unsigned GAP_W  = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        state, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [GAP_W-1:0]  gap_cnt, gap_d;
    logic [7:0]        gnt_d;
    logic [2:0]        sel_d;
    logic              valid_d;
    logic [2:0]        last_d;

    logic              pick_found;
    logic [2:0]        pick_idx;
    logic              hold_at_max;
    logic              timeout;
    logic              release_now;

    // Rotating priority search starting just after the most recent owner.
    always_comb begin
        logic [2:0] cand;
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        cand       = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_idx + 3'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_at_max = (hold_cnt >= HOLD_W'(MAX_HOLD));

`ifdef MUX8_RR_LOCK_EN
    assign timeout = hold_at_max & ~lock;
`else
    assign timeout = hold_at_max;
`endif

    assign release_now = done | ~req[sel] | timeout;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        gap_d   = gap_cnt;
        gnt_d   = gnt;
        sel_d   = sel;
        valid_d = sel_valid;
        last_d  = last_idx;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d   = 8'b1 << pick_idx;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                    state_d = S_GRANT;
                end
            end

            S_GRANT: begin
                if (release_now) begin
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                    last_d  = sel;
                    hold_d  = '0;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_W'(1);
                        state_d = S_GAP;
                    end else begin
                        gap_d   = '0;
                        state_d = S_IDLE;
                    end
                end else if (!hold_at_max) begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end

            S_GAP: begin
                if (gap_cnt >= GAP_W'(GAP_CYCLES)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                gnt_d   = 8'h00;
                valid_d = 1'b0;
                hold_d  = '0;
                gap_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight grant or gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            gnt       <= 8'h00;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            last_idx  <= 3'd7;
        end else begin
            state     <= state_d;
            hold_cnt  <= hold_d;
            gap_cnt   <= gap_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            sel_valid <= valid_d;
            last_idx  <= last_d;
        end
    end

    // Output invariants: grant is one-hot or zero and always agrees with sel/sel_valid.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_valid_match : assert property (@(posedge clk) disable iff (rst) sel_valid == (|gnt));
    a_sel_match   : assert property (@(posedge clk) disable iff (rst)
                                     sel_valid |-> (gnt == (8'b1 << sel)));

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched: directed vector table, hand sequences, and random
// stimulus compared against a cycle-level reference model.
module tb_mux8_rr_sched;

    localparam int unsigned MAX_HOLD   = 4;
    localparam int unsigned GAP_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       lock;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;
    logic [2:0] last_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (-1 = nobody), cycles held, gap cycles left.
    int m_owner = -1;
    int m_last  = 7;
    int m_sel   = 0;
    int m_held  = 0;
    int m_gap   = 0;

    mux8_rr_sched #(
        .MAX_HOLD  (MAX_HOLD),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
`ifdef MUX8_RR_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .sel      (sel),
        .sel_valid(sel_valid),
        .last_idx (last_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic [2:0] last;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] q, input logic d, input logic l);
        if (r) begin
            m_owner = -1;
            m_last  = 7;
            m_sel   = 0;
            m_held  = 0;
            m_gap   = 0;
        end else if (m_owner >= 0) begin
            if (d || !q[m_owner] || ((m_held >= MAX_HOLD) && !l)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = GAP_CYCLES;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (q != 8'h00) begin
            int pick;
            pick = -1;
            for (int k = 1; k <= 8; k++)
                if (pick < 0 && q[(m_last + k) % 8]) pick = (m_last + k) % 8;
            m_owner = pick;
            m_sel   = pick;
            m_held  = 1;
        end
    endtask

    task automatic cycle(input logic r, input logic [7:0] q, input logic d, input logic l);
        rst  = r;
        req  = q;
        done = d;
        lock = l;
        model_step(r, q, d, l);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check("model_gnt", gnt, eg);
        check("model_sel", 8'(sel), 8'(m_sel));
        check("model_valid", 8'(sel_valid), (m_owner >= 0) ? 8'h01 : 8'h00);
        check("model_last", 8'(last_idx), 8'(m_last));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        lock = 1'b0;

        // rst, req, done -> gnt, sel, valid, last
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 3'd7};
        tbl[1]  = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 3'd7};
        tbl[2]  = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 3'd7};
        tbl[3]  = '{1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[4]  = '{1'b0, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[5]  = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 3'd0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 3'd7};
        tbl[10] = '{1'b0, 8'h81, 1'b0, 8'h00, 3'd7, 1'b0, 3'd7};
        tbl[11] = '{1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 3'd7};
        tbl[12] = '{1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[13] = '{1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[14] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 3'd0};
        tbl[15] = '{1'b1, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 3'd7};
        tbl[16] = '{1'b0, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 3'd7};

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rst, tbl[i].req, tbl[i].done, 1'b0);
            check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            check($sformatf("tbl%0d_sel", i), 8'(sel), 8'(tbl[i].sel));
            check($sformatf("tbl%0d_valid", i), 8'(sel_valid), 8'(tbl[i].valid));
            check($sformatf("tbl%0d_last", i), 8'(last_idx), 8'(tbl[i].last));
        end

        // All requesting: rotation 0..7,0 with MAX_HOLD grant cycles and two free cycles.
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        for (int g = 0; g < 9; g++) begin
            logic [7:0] eg;
            eg = 8'h01 << (g % 8);
            for (int c = 0; c < 4; c++) begin
                cycle(1'b0, 8'hFF, 1'b0, 1'b0);
                check($sformatf("rot%0d_c%0d_gnt", g, c), gnt, eg);
                check($sformatf("rot%0d_c%0d_sel", g, c), 8'(sel), 8'(g % 8));
            end
            for (int c = 0; c < 2; c++) begin
                cycle(1'b0, 8'hFF, 1'b0, 1'b0);
                check($sformatf("rot%0d_gap%0d_gnt", g, c), gnt, 8'h00);
            end
        end

        // Owner 3 withdraws; next winner is the first set index above 3.
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h08, 1'b0, 1'b0);
        check("wd_grant3", gnt, 8'h08);
        cycle(1'b0, 8'h25, 1'b0, 1'b0);
        check("wd_release_gnt", gnt, 8'h00);
        check("wd_release_last", 8'(last_idx), 8'h03);
        cycle(1'b0, 8'h25, 1'b0, 1'b0);
        check("wd_idle_gnt", gnt, 8'h00);
        cycle(1'b0, 8'h25, 1'b0, 1'b0);
        check("wd_next_gnt", gnt, 8'h20);
        check("wd_next_sel", 8'(sel), 8'h05);

        // Reset in the middle of a grant to input 5.
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h20, 1'b0, 1'b0);
        cycle(1'b0, 8'h20, 1'b0, 1'b0);
        check("rst5_pre_gnt", gnt, 8'h20);
        cycle(1'b1, 8'h20, 1'b0, 1'b0);
        check("rst5_gnt", gnt, 8'h00);
        check("rst5_valid", 8'(sel_valid), 8'h00);
        check("rst5_last", 8'(last_idx), 8'h07);
        cycle(1'b0, 8'h21, 1'b0, 1'b0);
        check("rst5_after_gnt", gnt, 8'h01);

`ifdef MUX8_RR_LOCK_EN
        // Lock stretches a grant past MAX_HOLD; release follows the edge after lock drops.
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 8'h06, 1'b0, 1'b1);
            check($sformatf("lock_c%0d_gnt", c), gnt, 8'h02);
        end
        cycle(1'b0, 8'h06, 1'b0, 1'b0);
        check("lock_rel_gnt", gnt, 8'h00);
        check("lock_rel_last", 8'(last_idx), 8'h01);
        cycle(1'b0, 8'h06, 1'b0, 1'b0);
        check("lock_idle_gnt", gnt, 8'h00);
        cycle(1'b0, 8'h06, 1'b0, 1'b0);
        check("lock_next_gnt", gnt, 8'h04);
        check("lock_next_sel", 8'(sel), 8'h02);
`endif

        // Randomized run against the reference model.
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        check_model();
        begin
            logic [7:0] q;
            logic       l;
            q = 8'h00;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(3) == 0) q = 8'($urandom);
                if ($urandom_range(15) == 0) q = 8'h00;
                if ($urandom_range(15) == 0) q = 8'hFF;
`ifdef MUX8_RR_LOCK_EN
                l = ($urandom_range(2) == 0);
`else
                l = 1'b0;
`endif
                cycle(($urandom_range(299) == 0), q, ($urandom_range(6) == 0), l);
                check_model();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
